// File: rtl/theatre_pkg.sv
// Shared types for the theatre cue sequencer.
//   mode_e      : controller mode selected by a cue
//   seq_state_e : sequencer FSM states
//   cue_t       : one cue table entry (mode + dwell)
// Helpers: mode_onehot() maps a mode to {Play,Speaker,Music,House};
//          dwell() applies the "zero dwell means one cycle" rule.
package theatre_pkg;

    // Storage width of the cue dwell field; the sequencer's DUR_W must not exceed it.
    localparam int unsigned CUE_DUR_W = 8;

    typedef enum logic [1:0] {
        MODE_HOUSE   = 2'd0,
        MODE_MUSIC   = 2'd1,
        MODE_SPEAKER = 2'd2,
        MODE_PLAY    = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        GAP  = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } seq_state_e;

    typedef struct packed {
        mode_e                mode;
        logic [CUE_DUR_W-1:0] dur;
    } cue_t;

    function automatic logic [3:0] mode_onehot(input mode_e m);
        return 4'(1) << m;
    endfunction

    function automatic logic [CUE_DUR_W-1:0] dwell(input cue_t c);
        return (c.dur == '0) ? CUE_DUR_W'(1) : c.dur;
    endfunction

endpackage

// File: rtl/theatre_cue_timer.sv
// Loadable down-counter shared by cue dwell and blackout gap timing.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   load_i         : load load_val_i (wins over counting)
//   load_val_i     : value to load
//   hold_i         : freeze the count
//   expire_c_o     : combinational, high while the count is 1 (last cycle)
module theatre_cue_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         hold_i,
    output logic         expire_c_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: load, else decrement unless held or already empty.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (!hold_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_c_o = (count_q == W'(1));

endmodule

// File: rtl/theatre_cue_sequencer.sv
// Show-timeline scheduler for the theatre lighting/audio controller.
// Plays a loadable cue table (mode + dwell), inserting a blackout gap
// between cues, with pause, skip and emergency stop.
// Build option: define THEATRE_CUE_LOOP_EN to repeat the show from cue 0
// after the last cue instead of finishing (done then never asserts).
// Ports:
//   clk, reset (sync, active-low)
//   start/pause/skip/estop : operator controls
//   last_idx               : final cue index, sampled on accepted start
//   wr_en/wr_addr/wr_mode/wr_dur : cue table write port (IDLE/DONE only)
//   EN, House, Music, Speaker, Play : controller inputs (registered)
//   cue_idx, busy, done    : status (registered)
module theatre_cue_sequencer
    import theatre_pkg::*;
#(
    parameter  int unsigned NUM_CUES   = 8,
    parameter  int unsigned DUR_W      = 8,
    parameter  int unsigned GAP_CYCLES = 2,
    localparam int unsigned IDX_W      = $clog2(NUM_CUES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             skip,
    input  logic             estop,
    input  logic [IDX_W-1:0] last_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [1:0]       wr_mode,
    input  logic [DUR_W-1:0] wr_dur,
    output logic             EN,
    output logic             House,
    output logic             Music,
    output logic             Speaker,
    output logic             Play,
    output logic [IDX_W-1:0] cue_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TMR_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;

    cue_t             cue_tab [NUM_CUES];
    cue_t             wr_cue_c, cue0_c, nxt_cue_c;
    logic             wr_ok_c, last_cue_c, show_end_c;
    logic [IDX_W-1:0] nxt_idx_c;

    seq_state_e       state_q, state_d, resume_q, resume_d, eff_c;
    logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d;
    logic [3:0]       modes_q, modes_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             tmr_load_c, tmr_hold_c, tmr_expire_c;
    logic [TMR_W-1:0] tmr_val_c;

    assign wr_ok_c        = (state_q == IDLE) || (state_q == DONE);
    assign wr_cue_c.mode  = mode_e'(wr_mode);
    assign wr_cue_c.dur   = CUE_DUR_W'(wr_dur);

    // A write to entry 0 in the same cycle as start is forwarded so the show uses it.
    assign cue0_c = (wr_ok_c && wr_en && (wr_addr == '0)) ? wr_cue_c : cue_tab[0];

    assign last_cue_c = (idx_q == last_q);
`ifdef THEATRE_CUE_LOOP_EN
    assign show_end_c = 1'b0;
    assign nxt_idx_c  = last_cue_c ? '0 : idx_q + IDX_W'(1);
`else
    assign show_end_c = last_cue_c;
    assign nxt_idx_c  = idx_q + IDX_W'(1);
`endif
    assign nxt_cue_c = cue_tab[nxt_idx_c];

    // Cue table storage; not reset, written only while no show is active.
    always_ff @(posedge clk) begin
        if (reset && wr_en && wr_ok_c) begin
            cue_tab[wr_addr] <= wr_cue_c;
        end
    end

    theatre_cue_timer #(.W(TMR_W)) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_val_c),
        .hold_i     (tmr_hold_c),
        .expire_c_o (tmr_expire_c)
    );

    // Next-state and next-output logic. HOLD dispatches as its remembered
    // sub-state once pause drops, so the release cycle counts normally.
    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        idx_d      = idx_q;
        last_d     = last_q;
        modes_d    = modes_q;
        tmr_load_c = 1'b0;
        tmr_hold_c = 1'b1;
        tmr_val_c  = '0;
        eff_c      = (state_q == HOLD) ? resume_q : state_q;

        if (estop) begin
            state_d = IDLE;
            idx_d   = '0;
            modes_d = '0;
        end else begin
            case (eff_c)
                IDLE, DONE: begin
                    if (start) begin
                        state_d    = RUN;
                        idx_d      = '0;
                        last_d     = (32'(last_idx) >= NUM_CUES) ? IDX_W'(NUM_CUES - 1) : last_idx;
                        tmr_load_c = 1'b1;
                        tmr_val_c  = TMR_W'(dwell(cue0_c));
                        modes_d    = mode_onehot(cue0_c.mode);
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d  = HOLD;
                        resume_d = RUN;
                    end else if (tmr_expire_c || skip) begin
                        if (show_end_c) begin
                            state_d = DONE;
                            modes_d = '0;
                        end else if (GAP_CYCLES == 0) begin
                            state_d    = RUN;
                            idx_d      = nxt_idx_c;
                            tmr_load_c = 1'b1;
                            tmr_val_c  = TMR_W'(dwell(nxt_cue_c));
                            modes_d    = mode_onehot(nxt_cue_c.mode);
                        end else begin
                            state_d    = GAP;
                            tmr_load_c = 1'b1;
                            tmr_val_c  = TMR_W'(GAP_CYCLES);
                            modes_d    = '0;
                        end
                    end else begin
                        tmr_hold_c = 1'b0;
                    end
                end
                GAP: begin
                    if (pause) begin
                        state_d  = HOLD;
                        resume_d = GAP;
                    end else if (tmr_expire_c) begin
                        state_d    = RUN;
                        idx_d      = nxt_idx_c;
                        tmr_load_c = 1'b1;
                        tmr_val_c  = TMR_W'(dwell(nxt_cue_c));
                        modes_d    = mode_onehot(nxt_cue_c.mode);
                    end else begin
                        tmr_hold_c = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    modes_d = '0;
                end
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == GAP) || (state_d == HOLD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            resume_q <= RUN;
            idx_q    <= '0;
            last_q   <= '0;
            modes_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            modes_q  <= modes_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // The controller is enabled exactly while a show is in progress.
    assign EN      = busy_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cue_idx = idx_q;
    assign House   = modes_q[0];
    assign Music   = modes_q[1];
    assign Speaker = modes_q[2];
    assign Play    = modes_q[3];

endmodule

// File: tb/tb_theatre_cue_sequencer.sv
// Directed, self-checking bench for theatre_cue_sequencer
// (NUM_CUES=8, DUR_W=8, GAP_CYCLES=2). Mode vectors are {Play,Speaker,Music,House}.
module tb_theatre_cue_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, pause, skip, estop, wr_en;
    logic [2:0] last_idx, wr_addr, cue_idx;
    logic [1:0] wr_mode;
    logic [7:0] wr_dur;
    logic       EN, House, Music, Speaker, Play, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    theatre_cue_sequencer #(.NUM_CUES(8), .DUR_W(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .skip(skip),
        .estop(estop), .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_mode(wr_mode), .wr_dur(wr_dur), .EN(EN), .House(House), .Music(Music),
        .Speaker(Speaker), .Play(Play), .cue_idx(cue_idx), .busy(busy), .done(done)
    );

    typedef struct {
        logic       wr;
        logic [2:0] wa;
        logic [1:0] wm;
        logic [7:0] wd;
        logic       st;
        logic [2:0] li;
        logic       en;
        logic [3:0] md;
        logic [2:0] ix;
        logic       bz;
        logic       dn;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(input logic wr, input logic [2:0] wa, input logic [1:0] wm,
                                 input logic [7:0] wd, input logic st, input logic [2:0] li,
                                 input logic en, input logic [3:0] md, input logic [2:0] ix,
                                 input logic bz, input logic dn);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wm = wm; v.wd = wd; v.st = st; v.li = li;
        v.en = en; v.md = md; v.ix = ix; v.bz = bz; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic en, input logic [3:0] md,
                       input logic [2:0] ix, input logic bz, input logic dn);
        n_tests++;
        if ({EN, Play, Speaker, Music, House, cue_idx, busy, done} !== {en, md, ix, bz, dn}) begin
            n_fail++;
            $display("FAIL %s: got EN=%b modes=%b idx=%0d busy=%b done=%b, expected EN=%b modes=%b idx=%0d busy=%b done=%b",
                     nm, EN, {Play, Speaker, Music, House}, cue_idx, busy, done, en, md, ix, bz, dn);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, sample 1ns later, clear pulses.
    task automatic cyc(input logic s, input logic p, input logic k, input logic e);
        start = s; pause = p; skip = k; estop = e;
        @(posedge clk);
        #1;
        start = 1'b0; skip = 1'b0; wr_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] m, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_mode = m; wr_dur = d;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt;
        reset = 1'b0; start = 1'b0; pause = 1'b0; skip = 1'b0; estop = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_mode = '0; wr_dur = '0; last_idx = '0;

        // Reset, with start held to confirm reset dominates.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_start_held", 0, 4'b0000, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_state", 0, 4'b0000, 0, 0, 0);
        reset = 1'b1;

        // Basic show: House 3, gap 2, Speaker 2, then done; plus dwell 1/0 and write+start.
        vq.push_back(mkv(1, 0, 0, 8'd3, 0, 0,  0, 4'b0000, 0, 0, 0));
        vq.push_back(mkv(1, 1, 2, 8'd2, 0, 0,  0, 4'b0000, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 1, 1,  1, 4'b0001, 0, 1, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  1, 4'b0001, 0, 1, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  1, 4'b0001, 0, 1, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  1, 4'b0000, 0, 1, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  1, 4'b0000, 0, 1, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  1, 4'b0100, 1, 1, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  1, 4'b0100, 1, 1, 0));
`ifdef THEATRE_CUE_LOOP_EN
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  1, 4'b0000, 1, 1, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  1, 4'b0000, 1, 1, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  1, 4'b0001, 0, 1, 0));
`else
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  0, 4'b0000, 1, 0, 1));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 1,  0, 4'b0000, 1, 0, 1));
        vq.push_back(mkv(1, 0, 1, 8'd1, 1, 0,  1, 4'b0010, 0, 1, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 0,  0, 4'b0000, 0, 0, 1));
        vq.push_back(mkv(1, 0, 3, 8'd0, 1, 0,  1, 4'b1000, 0, 1, 0));
        vq.push_back(mkv(0, 0, 0, 8'd0, 0, 0,  0, 4'b0000, 0, 0, 1));
`endif
        for (int i = 0; i < vq.size(); i++) begin
            wr_en = vq[i].wr; wr_addr = vq[i].wa; wr_mode = vq[i].wm; wr_dur = vq[i].wd;
            last_idx = vq[i].li;
            cyc(vq[i].st, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d", i), vq[i].en, vq[i].md, vq[i].ix, vq[i].bz, vq[i].dn);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("estop_to_idle", 0, 4'b0000, 0, 0, 0);
        last_idx = 3'd1;

        // Pause for 4 cycles during cue 0 (skip while paused ignored): House lasts 7.
        wr(3'd0, 2'd0, 8'd3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cnt = House ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, (i == 1), 1'b0);
            chk($sformatf("pause_hold%0d", i), 1, 4'b0001, 0, 1, 0);
            if (House) cnt++;
        end
        for (int i = 0; i < 20 && House; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (House) cnt++;
        end
        chk_int("pause_house_cycles", cnt, 7);
        chk("pause_gap0", 1, 4'b0000, 0, 1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pause_gap1", 1, 4'b0000, 0, 1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pause_spk0", 1, 4'b0100, 1, 1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pause_spk1", 1, 4'b0100, 1, 1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pause_estop", 0, 4'b0000, 0, 0, 0);

        // Skip in cycle 5 of a 50-cycle Play cue.
        wr(3'd0, 2'd3, 8'd50);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("skip_play_c1", 1, 4'b1000, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("skip_play_c5", 1, 4'b1000, 0, 1, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("skip_gap0", 1, 4'b0000, 0, 1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("skip_gap1", 1, 4'b0000, 0, 1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("skip_cue1", 1, 4'b0100, 1, 1, 0);

        // Emergency stop mid cue 1, with start held alongside.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("estop_mid_cue", 0, 4'b0000, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("estop_start_ignored", 0, 4'b0000, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("estop_released", 0, 4'b0000, 0, 0, 0);

        // Table write during RUN is dropped; cue 1 still Speaker for 2 cycles.
        wr(3'd0, 2'd0, 8'd3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 3'd1; wr_mode = 2'd1; wr_dur = 8'd9;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_write_house", 1, 4'b0001, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 12 && !Speaker; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12 && Speaker; i++) begin
            if (Music) cnt = 99;
            cnt++;
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk_int("busy_write_spk_cycles", cnt, 2);
`ifdef THEATRE_CUE_LOOP_EN
        chk("loop_gap_after_last", 1, 4'b0000, 1, 1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("loop_house_again", 1, 4'b0001, 0, 1, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
`else
        chk("busy_write_done", 0, 4'b0000, 1, 0, 1);
`endif

        // Reset during the gap; the table survives reset.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_pre_gap", 1, 4'b0000, 0, 1, 0);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_gap", 0, 4'b0000, 0, 0, 0);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_table_kept", 1, 4'b0001, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
